sym_err_mer_meter: RTL and testbench
====================================

Name: sym_err_mer_meter

Overview:
- Multi-channel symbol-error and MER measurement engine for the QPSK/4-ASK test chain.
- Per channel, it delays the LFSR reference symbol by the DUT and slicer pipeline latency and compares it with the slicer decision.
- Over a power-of-two symbol window it counts symbol errors and accumulates squared slicer error, then latches the per-window results for readout via SignalTap or ISSP.
- It generalises the fixed two-channel, three-deep compare to NCH channels, with parametrised delay, window length and a continuous mode.

Parameters:
- NCH, 2: number of channels (I, Q, ...).
- SYM_W, 2: bits per reference/slice symbol.
- DELAY, 3: reference-symbol delay in symbol periods, ≥1.
- ERR_W, 18: signed error width (1s17).
- WIN_LOG2, 16: window = 2^WIN_LOG2 symbols.
- CNT_W, WIN_LOG2+1: symbol-error counter width.
- ACC_W, 2*ERR_W+WIN_LOG2: squared-error accumulator width.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sym_clk_en  in  1  symbol-rate enable, one sys_clk cycle wide.
- start  in  1  level-sampled; begins a measurement when in IDLE.
- continuous  in  1  1 = restart windows back-to-back.
- ref_sym  in  NCH*SYM_W  LFSR symbols; channel k at [k*SYM_W +: SYM_W].
- slice  in  NCH*SYM_W  slicer decisions, same packing.
- error  in  NCH*ERR_W  signed slicer error, same packing.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse when results update.
- sym_err_cnt  out  NCH*CNT_W  latched symbol-error count per channel.
- err_sq_acc  out  NCH*ACC_W  latched sum of error² per channel.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All delay-line stages, counters, accumulators and outputs are cleared to 0.
  - Reset overrides every other input, including mid-window.
- Delay line: per channel, DELAY stages of SYM_W bits. Shifts only on sym_clk_en, in every state. Stage 0 takes ref_sym; the compare uses stage DELAY-1.
- States:
  - IDLE: start=1 goes to FLUSH, with the flush counter cleared.
  - FLUSH: counts DELAY sym_clk_en pulses, then goes to MEASURE. The window counter, error counters and accumulators clear on entry.
  - MEASURE: on each sym_clk_en, per channel:
    - The error counter increments if stage[DELAY-1] ≠ slice.
    - The accumulator adds error×error, a signed product zero-extended to ACC_W.
    - The window counter increments.
    - The enable that completes symbol 2^WIN_LOG2 moves the state to DONE on the next edge.
  - DONE (exactly one sys_clk):
    - sym_err_cnt and err_sq_acc are loaded from the working registers.
    - result_valid=1.
    - Next state is MEASURE if continuous=1, with working registers cleared and no flush. Otherwise it is IDLE.
- Enable during DONE: a sym_clk_en arriving in the DONE cycle is counted as symbol 1 of the next window when continuous=1. When continuous=0 it is ignored.
- Outputs: held between DONE cycles. result_valid is 0 except in DONE.
- start handling: start in any state other than IDLE is ignored. Dropping continuous mid-window ends after the current window.
- Arithmetic:
  - The squared error is at most 2^(2*ERR_W-2), so ACC_W cannot overflow for a full window. No saturation logic is required.
  - The error counter maximum is 2^WIN_LOG2, which fits CNT_W.
- Boundary: with a window of W symbols, sym_clk_en arriving one per DELAY+W enables gives exactly one result_valid.

Test Plan (NCH=2, DELAY=3, WIN_LOG2=4, sym_clk_en every 4 sys_clk):
- Reset: assert reset for 2 cycles mid-MEASURE → busy=0, result_valid=0, all outputs 0. The next start flushes 3 symbols again.
- Perfect link: slice = ref_sym delayed by 3 symbols, error=+5 on both channels, start pulse → one result_valid after 19 enables; sym_err_cnt={0,0}; err_sq_acc={400,400}; busy drops the cycle after DONE.
- Errors: ch0 slice corrupted on window symbols 2, 7 and 16, ch1 clean, error ch0 = -3 → sym_err_cnt ch0=3, ch1=0; err_sq_acc ch0=144.
- Full scale: error ch1 = -131072 for the whole window → err_sq_acc ch1 = 2^38 = 274877906944, with no wrap.
- Continuous: continuous=1, start once → result_valid pulses exactly 16 enables apart, with the first after 19. Counts are independent per window. Dropping continuous → returns to IDLE after the current window.
- Ignored start and DONE-coincident enable: start held high during MEASURE → no restart. A sym_clk_en aligned with DONE in continuous mode → counted in the next window, so every window totals 16 symbols.

Source files
------------

// File: rtl/sym_err_mer_meter.sv
// Multi-channel symbol-error and MER measurement engine.
// Each channel delays its reference symbol by DELAY symbol periods, compares
// it with the slicer decision and accumulates squared slicer error over a
// 2^WIN_LOG2 symbol window. Per-window results are latched for readout.
module sym_err_mer_meter #(
  parameter int NCH      = 2,
  parameter int SYM_W    = 2,
  parameter int DELAY    = 3,
  parameter int ERR_W    = 18,
  parameter int WIN_LOG2 = 16,
  parameter int CNT_W    = WIN_LOG2 + 1,
  parameter int ACC_W    = 2 * ERR_W + WIN_LOG2
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   sym_clk_en,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [NCH*SYM_W-1:0]   ref_sym,
  input  logic [NCH*SYM_W-1:0]   slice,
  input  logic [NCH*ERR_W-1:0]   error,
  output logic                   busy,
  output logic                   result_valid,
  output logic [NCH*CNT_W-1:0]   sym_err_cnt,
  output logic [NCH*ACC_W-1:0]   err_sq_acc
);

  // Flush counter only needs to reach DELAY-1.
  localparam int FL_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int PAD_W = ACC_W - 2 * ERR_W;

  localparam logic [FL_W-1:0]     FL_LAST  = FL_W'(DELAY - 1);
  localparam logic [FL_W-1:0]     FL_ZERO  = {FL_W{1'b0}};
  localparam logic [FL_W-1:0]     FL_ONE   = FL_W'(1'b1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0] WIN_ZERO = {WIN_LOG2{1'b0}};
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1'b1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
  localparam logic [ACC_W-1:0]    ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [SYM_W-1:0]    SYM_ZERO = {SYM_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [FL_W-1:0]     flush_q, flush_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [SYM_W-1:0]    dly_q [NCH][DELAY];
  logic [SYM_W-1:0]    dly_d [NCH][DELAY];
  logic [CNT_W-1:0]    err_cnt_q [NCH];
  logic [CNT_W-1:0]    err_cnt_d [NCH];
  logic [ACC_W-1:0]    acc_q [NCH];
  logic [ACC_W-1:0]    acc_d [NCH];
  logic [NCH*CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [NCH*ACC_W-1:0] out_acc_q, out_acc_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic [NCH-1:0]      mis_s;
  logic [ACC_W-1:0]    sq_s [NCH];

  // Per-channel symbol mismatch and zero-extended squared error.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [ERR_W-1:0]   err_s;
    logic signed [2*ERR_W-1:0] err_x_s;
    logic signed [2*ERR_W-1:0] prod_s;
    assign err_s    = error[k*ERR_W +: ERR_W];
    assign err_x_s  = {{ERR_W{err_s[ERR_W-1]}}, err_s};
    assign prod_s   = err_x_s * err_x_s;
    assign sq_s[k]  = {{PAD_W{1'b0}}, prod_s};
    assign mis_s[k] = (dly_q[k][DELAY-1] != slice[k*SYM_W +: SYM_W]);
  end

  // Reference delay line: shifts on every symbol enable, independent of state.
  always_comb begin
    dly_d = dly_q;
    if (sym_clk_en) begin
      for (int k = 0; k < NCH; k++) begin
        dly_d[k][0] = ref_sym[k*SYM_W +: SYM_W];
        for (int s = 1; s < DELAY; s++) begin
          dly_d[k][s] = dly_q[k][s-1];
        end
      end
    end else begin
      dly_d = dly_q;
    end
  end

  // Delay line storage.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        for (int s = 0; s < DELAY; s++) begin
          dly_q[k][s] <= SYM_ZERO;
        end
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  // Measurement FSM: next state, working counters and result latching.
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    win_d     = win_q;
    err_cnt_d = err_cnt_q;
    acc_d     = acc_q;
    out_cnt_d = out_cnt_q;
    out_acc_d = out_acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FLUSH;
          flush_d = FL_ZERO;
          win_d   = WIN_ZERO;
          for (int k = 0; k < NCH; k++) begin
            err_cnt_d[k] = CNT_ZERO;
            acc_d[k]     = ACC_ZERO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (sym_clk_en) begin
          if (flush_q == FL_LAST) begin
            state_d = ST_MEASURE;
            flush_d = FL_ZERO;
          end else begin
            flush_d = flush_q + FL_ONE;
          end
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_MEASURE: begin
        if (sym_clk_en) begin
          for (int k = 0; k < NCH; k++) begin
            if (mis_s[k]) begin
              err_cnt_d[k] = err_cnt_q[k] + CNT_ONE;
            end else begin
              err_cnt_d[k] = err_cnt_q[k];
            end
            acc_d[k] = acc_q[k] + sq_s[k];
          end
          win_d = win_q + WIN_ONE;
          if (win_q == WIN_LAST) begin
            // Results become visible together with result_valid in DONE.
            state_d = ST_DONE;
            for (int k = 0; k < NCH; k++) begin
              out_cnt_d[k*CNT_W +: CNT_W] = err_cnt_d[k];
              out_acc_d[k*ACC_W +: ACC_W] = acc_d[k];
            end
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_DONE: begin
        if (continuous) begin
          state_d = ST_MEASURE;
          // An enable coinciding with DONE is symbol 1 of the next window.
          if (sym_clk_en) begin
            win_d = WIN_ONE;
            for (int k = 0; k < NCH; k++) begin
              err_cnt_d[k] = mis_s[k] ? CNT_ONE : CNT_ZERO;
              acc_d[k]     = sq_s[k];
            end
          end else begin
            win_d = WIN_ZERO;
            for (int k = 0; k < NCH; k++) begin
              err_cnt_d[k] = CNT_ZERO;
              acc_d[k]     = ACC_ZERO;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      flush_q   <= FL_ZERO;
      win_q     <= WIN_ZERO;
      for (int k = 0; k < NCH; k++) begin
        err_cnt_q[k] <= CNT_ZERO;
        acc_q[k]     <= ACC_ZERO;
      end
      out_cnt_q <= {(NCH*CNT_W){1'b0}};
      out_acc_q <= {(NCH*ACC_W){1'b0}};
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      win_q     <= win_d;
      err_cnt_q <= err_cnt_d;
      acc_q     <= acc_d;
      out_cnt_q <= out_cnt_d;
      out_acc_q <= out_acc_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign sym_err_cnt  = out_cnt_q;
  assign err_sq_acc   = out_acc_q;

endmodule

// File: tb/tb_sym_err_mer_meter.sv
// Directed bench for sym_err_mer_meter: NCH=2, DELAY=3, 16-symbol window,
// symbol enable every 4 clocks unless a test shortens the gap.
module tb_sym_err_mer_meter;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        sym_clk_en;
  logic        start;
  logic        continuous;
  logic [3:0]  ref_sym;
  logic [3:0]  slice;
  logic [35:0] error;
  logic        busy;
  logic        result_valid;
  logic [9:0]  sym_err_cnt;
  logic [79:0] err_sq_acc;

  sym_err_mer_meter #(
    .NCH(2), .SYM_W(2), .DELAY(3), .ERR_W(18), .WIN_LOG2(4), .CNT_W(5), .ACC_W(40)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start),
    .continuous(continuous), .ref_sym(ref_sym), .slice(slice), .error(error),
    .busy(busy), .result_valid(result_valid), .sym_err_cnt(sym_err_cnt),
    .err_sq_acc(err_sq_acc)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int en_count = 0;
  int sym_n = 0;
  int en_base;
  int b;
  logic [3:0] hist0, hist1, hist2;

  // Result-pulse monitor: records enable index and outputs for each pulse.
  int          rv_count = 0;
  int          rv_at  [16];
  logic [9:0]  rv_cnt [16];
  logic [79:0] rv_acc [16];

  always @(negedge sys_clk) begin
    if (result_valid) begin
      if (rv_count < 16) begin
        rv_at[rv_count]  <= en_count;
        rv_cnt[rv_count] <= sym_err_cnt;
        rv_acc[rv_count] <= err_sq_acc;
      end
      rv_count <= rv_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One symbol: slice mirrors the reference from 3 symbols ago, optionally
  // corrupted per channel; then wait so the next enable is 'gap' clocks later.
  task automatic do_sym(input logic [1:0] corr, input logic [17:0] e0,
                        input logic [17:0] e1, input int gap);
    logic [3:0] r;
    logic [3:0] s;
    @(negedge sys_clk);
    r = {2'(sym_n >> 1) ^ 2'b01, 2'(sym_n)};
    s = {hist2[3:2] ^ {1'b0, corr[1]}, hist2[1:0] ^ {1'b0, corr[0]}};
    hist2 = hist1;
    hist1 = hist0;
    hist0 = r;
    ref_sym = r;
    slice = s;
    error = {e1, e0};
    sym_clk_en = 1'b1;
    @(posedge sys_clk);
    en_count++;
    sym_n++;
    #1 sym_clk_en = 1'b0;
    repeat (gap - 1) @(posedge sys_clk);
  endtask

  task automatic start_pulse();
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  corr;
    logic [17:0] e0, e1;
    reset = 1'b1; sym_clk_en = 1'b0; start = 1'b0; continuous = 1'b0;
    ref_sym = 4'h0; slice = 4'h0; error = 36'h0;
    hist0 = 4'h0; hist1 = 4'h0; hist2 = 4'h0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valid", 64'(result_valid), 64'd0);
    check_val("rst_cnt", 64'(sym_err_cnt), 64'd0);
    check_val("rst_acc_lo", 64'(err_sq_acc[39:0]), 64'd0);

    // Perfect link, error +5 on both channels.
    start_pulse();
    check_val("perf_busy_start", 64'(busy), 64'd1);
    en_base = en_count; b = rv_count;
    for (int n = 1; n <= 18; n++) do_sym(2'b00, 18'h00005, 18'h00005, 4);
    @(negedge sys_clk);
    check_val("perf_no_early", 64'(rv_count - b), 64'd0);
    do_sym(2'b00, 18'h00005, 18'h00005, 4);
    @(negedge sys_clk);
    check_val("perf_pulses", 64'(rv_count - b), 64'd1);
    check_val("perf_at", 64'(rv_at[b] - en_base), 64'd19);
    check_val("perf_cnt0", 64'(rv_cnt[b][4:0]), 64'd0);
    check_val("perf_cnt1", 64'(rv_cnt[b][9:5]), 64'd0);
    check_val("perf_acc0", 64'(rv_acc[b][39:0]), 64'd400);
    check_val("perf_acc1", 64'(rv_acc[b][79:40]), 64'd400);
    check_val("perf_busy_end", 64'(busy), 64'd0);
    check_val("perf_hold_acc0", 64'(err_sq_acc[39:0]), 64'd400);

    // Errors on ch0 symbols 2,7,16; full-scale error on ch1; start held high.
    @(negedge sys_clk);
    start = 1'b1;
    en_base = en_count; b = rv_count;
    for (int n = 1; n <= 19; n++) begin
      corr = (n == 5 || n == 10 || n == 19) ? 2'b01 : 2'b00;
      do_sym(corr, 18'h3FFFD, 18'h20000, 4);
      if (n == 10) begin
        @(negedge sys_clk);
        start = 1'b0;
        check_val("err_busy_mid", 64'(busy), 64'd1);
      end
    end
    @(negedge sys_clk);
    check_val("err_pulses", 64'(rv_count - b), 64'd1);
    check_val("err_at", 64'(rv_at[b] - en_base), 64'd19);
    check_val("err_cnt0", 64'(rv_cnt[b][4:0]), 64'd3);
    check_val("err_cnt1", 64'(rv_cnt[b][9:5]), 64'd0);
    check_val("err_acc0", 64'(rv_acc[b][39:0]), 64'd144);
    check_val("fs_acc1", 64'(rv_acc[b][79:40]), 64'd274877906944);
    check_val("err_busy_end", 64'(busy), 64'd0);

    // Continuous: three windows, DONE-coincident enable, then drop continuous.
    @(negedge sys_clk);
    continuous = 1'b1;
    start_pulse();
    en_base = en_count; b = rv_count;
    for (int n = 1; n <= 51; n++) begin
      if (n <= 19) begin
        e0 = 18'h00001; e1 = 18'h00002;
      end else if (n <= 35) begin
        e0 = 18'h00003; e1 = 18'h00000;
      end else begin
        e0 = 18'h00002; e1 = 18'h00001;
      end
      corr = (n == 8) ? 2'b10 :
             ((n == 20 || n == 21 || n == 36) ? 2'b01 : 2'b00);
      do_sym(corr, e0, e1, (n == 35) ? 1 : 4);
      if (n == 40) begin
        @(negedge sys_clk);
        continuous = 1'b0;
      end
    end
    repeat (8) @(negedge sys_clk);
    check_val("cont_pulses", 64'(rv_count - b), 64'd3);
    check_val("cont_at1", 64'(rv_at[b] - en_base), 64'd19);
    check_val("cont_at2", 64'(rv_at[b+1] - en_base), 64'd35);
    check_val("cont_at3", 64'(rv_at[b+2] - en_base), 64'd51);
    check_val("cont_w1_cnt0", 64'(rv_cnt[b][4:0]), 64'd0);
    check_val("cont_w1_cnt1", 64'(rv_cnt[b][9:5]), 64'd1);
    check_val("cont_w1_acc0", 64'(rv_acc[b][39:0]), 64'd16);
    check_val("cont_w1_acc1", 64'(rv_acc[b][79:40]), 64'd64);
    check_val("cont_w2_cnt0", 64'(rv_cnt[b+1][4:0]), 64'd2);
    check_val("cont_w2_cnt1", 64'(rv_cnt[b+1][9:5]), 64'd0);
    check_val("cont_w2_acc0", 64'(rv_acc[b+1][39:0]), 64'd144);
    check_val("cont_w2_acc1", 64'(rv_acc[b+1][79:40]), 64'd0);
    check_val("cont_w3_cnt0", 64'(rv_cnt[b+2][4:0]), 64'd1);
    check_val("cont_w3_acc0", 64'(rv_acc[b+2][39:0]), 64'd64);
    check_val("cont_w3_acc1", 64'(rv_acc[b+2][79:40]), 64'd16);
    check_val("cont_busy_end", 64'(busy), 64'd0);

    // Reset in the middle of a window.
    start_pulse();
    b = rv_count;
    for (int n = 1; n <= 8; n++) do_sym(2'b11, 18'h00007, 18'h00007, 4);
    @(negedge sys_clk);
    check_val("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    hist0 = 4'h0; hist1 = 4'h0; hist2 = 4'h0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_valid", 64'(result_valid), 64'd0);
    check_val("mid_rst_cnt", 64'(sym_err_cnt), 64'd0);
    check_val("mid_rst_acc0", 64'(err_sq_acc[39:0]), 64'd0);
    check_val("mid_rst_acc1", 64'(err_sq_acc[79:40]), 64'd0);
    check_val("mid_rst_nopulse", 64'(rv_count - b), 64'd0);

    // Measurement after reset flushes 3 symbols again.
    start_pulse();
    en_base = en_count; b = rv_count;
    for (int n = 1; n <= 19; n++) do_sym(2'b00, 18'h00005, 18'h00004, 4);
    @(negedge sys_clk);
    check_val("post_pulses", 64'(rv_count - b), 64'd1);
    check_val("post_at", 64'(rv_at[b] - en_base), 64'd19);
    check_val("post_cnt", 64'(rv_cnt[b]), 64'd0);
    check_val("post_acc0", 64'(rv_acc[b][39:0]), 64'd400);
    check_val("post_acc1", 64'(rv_acc[b][79:40]), 64'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
